// File: rtl/gamma_pulse_scheduler.sv
// Gamma-cycle sequencer: accepts a spike-time vector, clears and drives a race-logic
// datapath with pulse-width spikes, timestamps the first datapath output, returns the result.
module gamma_pulse_scheduler #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int N_CH              = 2,
  localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH),
  localparam int LIMIT            = GAMMA_CYCLE_WIDTH - PULSE_WIDTH
) (
  input  logic                 aclk,
  input  logic                 grst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*TW-1:0]   in_vals,
  output logic [N_CH-1:0]      pulse_o,
  output logic                 dp_grst,
  input  logic                 dp_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [TW-1:0]        out_time,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid/ready are registered, and in_ready and out_valid are never high together.
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, ACTIVE = 2'd2, REPORT = 2'd3} state_t;

  localparam logic [TW-1:0] LAST    = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW:0]   LIMIT_W = (TW+1)'(LIMIT);
  localparam logic [TW:0]   PW_W    = (TW+1)'(PULSE_WIDTH);

  state_t               state, state_nx;
  logic [TW-1:0]        tick, tick_nx;
  logic [N_CH*TW-1:0]   vals;
  logic [N_CH-1:0]      pulse_nx;

  assign dbg_state = state;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)     state_nx = CLEAR;
      CLEAR:                     state_nx = ACTIVE;
      ACTIVE:  if (tick == LAST) state_nx = REPORT;
      REPORT:  if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Pulses are registered one cycle ahead: compute the pattern for the tick about to start.
  always_comb begin
    tick_nx  = (state == CLEAR) ? '0 : tick + 1'b1;
    pulse_nx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((state_nx == ACTIVE) &&
          ({1'b0, vals[i*TW +: TW]} < LIMIT_W) &&
          (tick_nx >= vals[i*TW +: TW]) &&
          ({1'b0, tick_nx} < ({1'b0, vals[i*TW +: TW]} + PW_W)))
        pulse_nx[i] = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      in_ready  <= 1'b1;
      dp_grst   <= 1'b1;
      out_valid <= 1'b0;
      pulse_o   <= '0;
      out_hit   <= 1'b0;
      out_time  <= '0;
      vals      <= '0;
      tick      <= '0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      dp_grst   <= (state_nx != ACTIVE);
      out_valid <= (state_nx == REPORT);
      pulse_o   <= pulse_nx;
      if (state == IDLE && in_valid) vals <= in_vals;
      case (state)
        CLEAR: begin
          tick     <= '0;
          out_hit  <= 1'b0;
          out_time <= '0;
        end
        ACTIVE: begin
          if (tick != LAST) tick <= tick + 1'b1;
          // Only the first high sample of the gamma cycle is recorded.
          if (!out_hit && dp_q) begin
            out_hit  <= 1'b1;
            out_time <= tick;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_pulse_scheduler.sv
// Bench for gamma_pulse_scheduler: directed and random vectors against a tick-level model
// of the pulse rules, with a per-cycle compare process and a result queue.
module tb_gamma_pulse_scheduler;
  localparam int GCW   = 16;
  localparam int PW    = 8;
  localparam int NCH   = 2;
  localparam int TW    = 4;
  localparam int LIMIT = GCW - PW;

  logic            aclk = 1'b0;
  logic            grst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NCH*TW-1:0] in_vals;
  logic [NCH-1:0]  pulse_o;
  logic            dp_grst;
  logic            dp_q;
  logic            out_valid;
  logic            out_ready;
  logic            out_hit;
  logic [TW-1:0]   out_time;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  // Model: phase -1 unknown, 0 idle, 1 clear, 2 active, 3 report.
  int phase      = -1;
  int m_tick     = 0;
  int m_v[2]     = '{0, 0};
  int force_tick = -1;
  logic [TW:0] exp_q[$];

  gamma_pulse_scheduler #(.GAMMA_CYCLE_WIDTH(GCW), .PULSE_WIDTH(PW), .N_CH(NCH)) dut (
    .aclk(aclk), .grst_n(grst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vals(in_vals), .pulse_o(pulse_o), .dp_grst(dp_grst), .dp_q(dp_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_time(out_time), .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 aclk = ~aclk;

  // In forced mode dp_q is also high outside ACTIVE, which the DUT must ignore.
  assign dp_q = (force_tick >= 0) ? ((phase != 2) || (m_tick == force_tick)) : |pulse_o;

  function automatic bit model_pulse(input int v, input int k);
    return (v < LIMIT) && (k >= v) && (k < v + PW);
  endfunction

  function automatic logic [TW:0] model_result(input int v0, input int v1, input int ft);
    for (int k = 0; k < GCW; k++) begin
      bit dq;
      dq = (ft >= 0) ? (k == ft) : (model_pulse(v0, k) | model_pulse(v1, k));
      if (dq) return {1'b1, k[TW-1:0]};
    end
    return '0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / compare process
  always @(negedge aclk) begin
    if (phase >= 0) begin
      logic [NCH-1:0] exp_p;
      exp_p = '0;
      if (phase == 2) exp_p = {model_pulse(m_v[1], m_tick), model_pulse(m_v[0], m_tick)};
      chk("in_ready", in_ready, phase == 0);
      chk("dp_grst", dp_grst, phase != 2);
      chk("out_valid", out_valid, phase == 3);
      chk("pulse_o", pulse_o, exp_p);
      if (phase == 3) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exp_q: report phase with no expected result at %0t", $time);
        end else begin
          chk("out_hit", out_hit, exp_q[0][TW]);
          chk("out_time", out_time, exp_q[0][TW-1:0]);
        end
      end
      if (!grst_n) begin
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_time", out_time, 0);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input int v0, input int v1, input int ft, input int abort_at,
                      output bit aborted);
    aborted    = 1'b0;
    in_vals    = {v1[TW-1:0], v0[TW-1:0]};
    in_valid   = 1'b1;
    force_tick = ft;
    step();
    in_valid = 1'b0;
    in_vals  = NCH*TW'($urandom);
    m_v[0]   = v0;
    m_v[1]   = v1;
    exp_q.push_back(model_result(v0, v1, ft));
    phase = 1;
    step();
    phase  = 2;
    m_tick = 0;
    for (int k = 1; k < GCW; k++) begin
      step();
      m_tick = k;
      if (k == abort_at) begin
        grst_n = 1'b0;
        #1;
        phase = 0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_dp_grst", dp_grst, 1);
        chk("abort_pulse_o", pulse_o, 0);
        chk("abort_out_valid", out_valid, 0);
        void'(exp_q.pop_front());
        force_tick = -1;
        step();
        step();
        grst_n  = 1'b1;
        aborted = 1'b1;
        return;
      end
    end
    step();
    phase = 3;
  endtask

  task automatic recv(input int hold);
    out_ready = 1'b0;
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    phase      = 0;
    force_tick = -1;
  endtask

  initial begin
    bit ab;
    grst_n    = 1'b1;
    in_valid  = 1'b0;
    in_vals   = '0;
    out_ready = 1'b0;
    #1;
    grst_n = 1'b0;
    phase  = 0;
    repeat (3) @(posedge aclk);
    #1;
    grst_n = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_dp_grst", dp_grst, 1);
    chk("idle_out_valid", out_valid, 0);

    send(2, 4, -1, -1, ab);
    chk("lit_a_hit", out_hit, 1);
    chk("lit_a_time", out_time, 2);
    recv(0);

    send(5, 5, -1, -1, ab);
    chk("lit_55_time", out_time, 5);
    recv(1);

    send(7, 7, -1, -1, ab);
    chk("lit_77_time", out_time, 7);
    recv(0);

    send(8, 15, -1, -1, ab);
    chk("lit_null_hit", out_hit, 0);
    chk("lit_null_time", out_time, 0);
    recv(2);

    send(3, 9, 15, -1, ab);
    chk("lit_late_hit", out_hit, 1);
    chk("lit_late_time", out_time, 15);
    recv(5);
    chk("bp_in_ready", in_ready, 1);

    send(1, 3, -1, 4, ab);
    chk("abort_flag", ab, 1);
    send(0, 0, -1, -1, ab);
    chk("lit_00_hit", out_hit, 1);
    chk("lit_00_time", out_time, 0);
    recv(0);

    for (int n = 0; n < 30; n++) begin
      int v0, v1, ft, ab_at;
      v0    = $urandom_range(0, 15);
      v1    = $urandom_range(0, 15);
      ft    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      ab_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : -1;
      send(v0, v1, ft, ab_at, ab);
      if (!ab) recv($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gamma_pulse_scheduler.md
# gamma_pulse_scheduler

Sequencer that drives one gamma cycle of a pulse-width temporal-coded datapath, such as an `exclusive_min` or other race-logic unit, and measures its output. It accepts a vector of per-channel spike times over a valid/ready handshake and clears the datapath. It then plays each channel as a PULSE_WIDTH-cycle pulse starting at its tick, timestamps the first assertion of the datapath output, and returns the result over a second valid/ready handshake.

## Interface
- GAMMA_CYCLE_WIDTH, 16: ACTIVE ticks per gamma cycle; power of two, ≥ 4.
- PULSE_WIDTH, 8: pulse length in aclk cycles; 1 ≤ PULSE_WIDTH < GAMMA_CYCLE_WIDTH.
- N_CH, 2: number of pulse channels.
- Derived TW = $clog2(GAMMA_CYCLE_WIDTH).
- Derived LIMIT = GAMMA_CYCLE_WIDTH − PULSE_WIDTH.
- aclk  in  1  sole clock; all logic is on the rising edge.
- grst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  spike-time vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_vals  in  N_CH*TW  channel i spike time in bits [i*TW +: TW].
- pulse_o  out  N_CH  pulse-width spikes to the datapath.
- dp_grst  out  1  active-high clear to the datapath.
- dp_q  in  1  datapath output; sampled by this block.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_hit  out  1  dp_q was seen high during the gamma cycle.
- out_time  out  TW  tick of the first dp_q high; 0 when out_hit = 0.

## Operation
- Four states: IDLE, CLEAR, ACTIVE, REPORT.
- IDLE:
  - in_ready = 1; dp_grst = 1; pulse_o = 0.
  - When in_valid & in_ready at a rising edge: latch in_vals and go to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle; dp_grst = 1; in_ready = 0.
  - Tick counter is set to 0 and the hit/time capture is cleared.
  - Next state is ACTIVE.
- ACTIVE:
  - Lasts exactly GAMMA_CYCLE_WIDTH cycles, numbered tick k = 0 … GAMMA_CYCLE_WIDTH−1; dp_grst = 0.
  - pulse_o[i] = 1 in tick k iff v_i < LIMIT and v_i ≤ k < v_i + PULSE_WIDTH.
  - A channel with v_i ≥ LIMIT is null and never pulses, so no pulse is ever truncated by the gamma boundary.
  - dp_q is sampled at the rising edge that ends each tick k. The first sample equal to 1 records out_time = k and out_hit = 1; later samples are ignored.
  - After tick GAMMA_CYCLE_WIDTH−1 the state goes to REPORT.
- REPORT:
  - out_valid = 1; out_hit and out_time are held stable; dp_grst = 1; pulse_o = 0; in_ready = 0.
  - When out_valid & out_ready at a rising edge: go to IDLE.
  - Back-pressure may last indefinitely.
- Tick counter is TW bits and runs only in ACTIVE. The end of ACTIVE is detected at k = GAMMA_CYCLE_WIDTH−1, with no reliance on wrap-around.
- All outputs are driven from registers and are glitch-free. pulse_o must not depend combinationally on dp_q.

## Timing
- Reset (grst_n = 0, any state, asynchronous) forces:
  - state = IDLE;
  - in_ready = 1, dp_grst = 1;
  - pulse_o = 0, out_valid = 0, out_hit = 0, out_time = 0;
  - latched values = 0.
- Reset mid-ACTIVE aborts the gamma cycle; no result is produced.
- Input accepted at edge E0 gives:
  - CLEAR during cycle E0→E1;
  - tick 0 during E1→E2;
  - out_valid rising at edge E0 + GAMMA_CYCLE_WIDTH + 1.
- Minimum vector-to-vector period is GAMMA_CYCLE_WIDTH + 3 cycles: IDLE accept, CLEAR, ACTIVE, and one REPORT cycle.
- in_ready and out_valid are never both 1.
- The datapath sees dp_grst fall at the start of tick 0 and rise at the start of REPORT.
- Equal spike times pulse in the same cycles; there is no per-channel skew.
- dp_q high during CLEAR, IDLE or REPORT is ignored.

## Test plan
Bench ties dp_q = |pulse_o (OR, i.e. a min model) unless stated otherwise. Parameters: GAMMA_CYCLE_WIDTH = 16, PULSE_WIDTH = 8, N_CH = 2, so LIMIT = 8.
- Reset and idle: hold grst_n = 0 for 3 cycles, then release → in_ready = 1, dp_grst = 1, pulse_o = 0, out_valid = 0.
- a first: vals {2, 4} → pulse_o[0] high on ticks 2–9, pulse_o[1] high on ticks 4–11 → out_hit = 1, out_time = 2. out_valid rises 17 edges after accept.
- Simultaneous and boundary:
  - vals {5, 5} → both pulses on ticks 5–12, out_time = 5.
  - vals {7, 7} → pulses on ticks 7–14, out_time = 7.
- Null channels: vals {8, 15} → pulse_o stays 0 for the whole gamma cycle → out_hit = 0, out_time = 0.
- Late dp_q and back-pressure:
  - Bench drives dp_q = 1 only at tick 15 → out_time = 15.
  - Hold out_ready = 0 for 5 cycles → out_valid, out_hit and out_time stay stable, in_ready = 0, dp_grst = 1.
  - Then assert out_ready → in_ready = 1 on the next cycle.
- Reset mid-operation: accept vals {1, 3}, then pull grst_n low at tick 4 → all outputs at reset values immediately, no out_valid. After release, a new vector {0, 0} gives out_time = 0.
